// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared widths and FSM state type for the I/Q sample accumulator
package iq_pkg;

  localparam int IQ_SAMPLE_W = 20;
  localparam int IQ_COEF_W   = 16;
  localparam int IQ_LUT_AW   = 8;
  localparam int IQ_PHASE_W  = 32;
  localparam int IQ_CNT_W    = 16;
  localparam int IQ_ACC_W    = IQ_SAMPLE_W + IQ_COEF_W + IQ_CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/iq_sincos_lut.sv
// rtl/iq_sincos_lut.sv - quarter-wave sin/cos ROM with registered cos and -sin outputs
module iq_sincos_lut
  import iq_pkg::*;
#(
  parameter int LUT_AW = IQ_LUT_AW,
  parameter int COEF_W = IQ_COEF_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [LUT_AW-1:0]        addr,
  output logic signed [COEF_W-1:0] cos_q,
  output logic signed [COEF_W-1:0] nsin_q
);

  localparam int  QN = 1 << (LUT_AW - 2);
  localparam real FS = real'((1 << (COEF_W - 1)) - 1);
  localparam real PI = 3.14159265358979323846;

  // First quadrant of sin, endpoints included so entry QN is exact full scale
  logic signed [COEF_W-1:0] rom [0:QN];

  for (genvar k = 0; k <= QN; k++) begin : g_rom
    assign rom[k] = COEF_W'($rtoi(FS * $sin(PI / 2.0 * real'(k) / real'(QN)) + 0.5));
  end

  function automatic logic signed [COEF_W-1:0] sin_at(input logic [LUT_AW-1:0] a);
    logic [LUT_AW-2:0]        fidx;
    logic [LUT_AW-2:0]        ridx;
    logic signed [COEF_W-1:0] mag;
    fidx = {1'b0, a[LUT_AW-3:0]};
    ridx = (LUT_AW-1)'(QN) - fidx;
    mag  = a[LUT_AW-2] ? rom[ridx] : rom[fidx];
    return a[LUT_AW-1] ? -mag : mag;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cos_q  <= '0;
      nsin_q <= '0;
    end else begin
      cos_q  <= sin_at(addr + LUT_AW'(QN));
      nsin_q <= -sin_at(addr);
    end
  end

endmodule

// File: rtl/sample_iq_accum.sv
// rtl/sample_iq_accum.sv - N-sample I/Q correlation against an NCO reference
// Optional overload counter port o_ovld_cnt when SAMPLE_IQ_OVLD_CNT_EN is defined.
module sample_iq_accum
  import iq_pkg::*;
#(
  parameter int SAMPLE_W = IQ_SAMPLE_W,
  parameter int COEF_W   = IQ_COEF_W,
  parameter int LUT_AW   = IQ_LUT_AW,
  parameter int PHASE_W  = IQ_PHASE_W,
  parameter int CNT_W    = IQ_CNT_W,
  localparam int ACC_W   = SAMPLE_W + COEF_W + CNT_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic                      i_sample_vld,
  input  logic                      i_overload,
  input  logic                      i_start,
  input  logic [PHASE_W-1:0]        i_phase_inc,
  input  logic [CNT_W-1:0]          i_num_samples,
  output logic                      o_busy,
  output logic                      o_done,
  output logic signed [ACC_W-1:0]   o_i_acc,
  output logic signed [ACC_W-1:0]   o_q_acc
`ifdef SAMPLE_IQ_OVLD_CNT_EN
  ,
  output logic [CNT_W-1:0]          o_ovld_cnt
`endif
);

  localparam int PROD_W = SAMPLE_W + COEF_W;

  state_t                     state, state_nxt;
  logic [PHASE_W-1:0]         phase, inc;
  logic [CNT_W-1:0]           num, cnt;
  logic                       accept, last, start_ok;
  logic                       s1_vld, s2_vld;
  logic signed [SAMPLE_W-1:0] s1_sample;
  logic signed [COEF_W-1:0]   cos_c, nsin_c;
  logic signed [PROD_W-1:0]   p_i, p_q;
  logic signed [ACC_W-1:0]    acc_i, acc_q, acc_i_nxt, acc_q_nxt;

  assign start_ok = (state == ST_IDLE) && i_start;
  assign accept   = (state == ST_RUN) && i_sample_vld && (num != '0);
  assign last     = accept && (cnt == num - CNT_W'(1));

  iq_sincos_lut #(.LUT_AW(LUT_AW), .COEF_W(COEF_W)) u_lut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .addr    (phase[PHASE_W-1 -: LUT_AW]),
    .cos_q   (cos_c),
    .nsin_q  (nsin_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // N=0 skips FLUSH: nothing entered the pipeline, so DONE follows RUN directly
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_RUN;
      ST_RUN: begin
        o_busy = 1'b1;
        if (num == '0) state_nxt = ST_DONE;
        else if (last) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        o_busy = 1'b1;
        if (!s1_vld) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign acc_i_nxt = acc_i + (s2_vld ? ACC_W'(p_i) : '0);
  assign acc_q_nxt = acc_q + (s2_vld ? ACC_W'(p_q) : '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase     <= '0;
      inc       <= '0;
      num       <= '0;
      cnt       <= '0;
      s1_vld    <= 1'b0;
      s1_sample <= '0;
      s2_vld    <= 1'b0;
      p_i       <= '0;
      p_q       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      o_i_acc   <= '0;
      o_q_acc   <= '0;
    end else begin
      s1_vld    <= accept;
      s1_sample <= i_sample;
      s2_vld    <= s1_vld;
      p_i       <= PROD_W'(s1_sample) * PROD_W'(cos_c);
      p_q       <= PROD_W'(s1_sample) * PROD_W'(nsin_c);
      if (start_ok) begin
        inc   <= i_phase_inc;
        num   <= i_num_samples;
        phase <= '0;
        cnt   <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end else begin
        if (accept) begin
          phase <= phase + inc;
          cnt   <= cnt + CNT_W'(1);
        end
        acc_i <= acc_i_nxt;
        acc_q <= acc_q_nxt;
      end
      // Final product lands in the same edge that publishes the results
      if (state != ST_DONE && state_nxt == ST_DONE) begin
        o_i_acc <= acc_i_nxt;
        o_q_acc <= acc_q_nxt;
      end
    end
  end

`ifdef SAMPLE_IQ_OVLD_CNT_EN
  logic [CNT_W-1:0] ovld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovld       <= '0;
      o_ovld_cnt <= '0;
    end else begin
      if (start_ok)                   ovld <= '0;
      else if (accept && i_overload)  ovld <= ovld + CNT_W'(1);
      if (state != ST_DONE && state_nxt == ST_DONE) o_ovld_cnt <= ovld;
    end
  end
`else
  logic unused_ovld;
  assign unused_ovld = i_overload;
`endif

endmodule

// File: tb/tb_sample_iq_accum.sv
// tb/tb_sample_iq_accum.sv - directed table-driven bench for sample_iq_accum
module tb_sample_iq_accum;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [19:0] sample = '0;
  logic               vld = 1'b0;
  logic               ovl = 1'b0;
  logic               start = 1'b0;
  logic [31:0]        inc = '0;
  logic [15:0]        num = '0;
  logic               busy, done;
  logic signed [51:0] iacc, qacc;
`ifdef SAMPLE_IQ_OVLD_CNT_EN
  logic [15:0]        ovld_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int tone[16];

  always #5 clk = ~clk;

  sample_iq_accum dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sample      (sample),
    .i_sample_vld  (vld),
    .i_overload    (ovl),
    .i_start       (start),
    .i_phase_inc   (inc),
    .i_num_samples (num),
    .o_busy        (busy),
    .o_done        (done),
    .o_i_acc       (iacc),
    .o_q_acc       (qacc)
`ifdef SAMPLE_IQ_OVLD_CNT_EN
    ,
    .o_ovld_cnt    (ovld_cnt)
`endif
  );

  typedef struct {
    int          smp;
    logic [31:0] inc;
    int          n;
    int          gap;
    longint      ei;
    longint      eq;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint exp, input longint tol);
    longint err;
    err = act - exp;
    if (err < 0) err = -err;
    total++;
    if (err >= tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Stray vld during the completion wait must be ignored outside RUN (and in RUN when N=0)
  task automatic run(input int smp, input logic [31:0] pinc, input int n, input int gap,
                     input bit use_tone, input int restart_at, input int ovl_n,
                     output longint ri, output longint rq, output int lat);
    @(posedge clk); #1;
    start = 1'b1; inc = pinc; num = 16'(n);
    @(posedge clk); #1;
    start = 1'b0; inc = 32'hdead_beef; num = 16'd3;
    check("busy_after_start", busy, 1);
    for (int k = 0; k < n; k++) begin
      sample = use_tone ? 20'(tone[k % 16]) : 20'(smp);
      vld = 1'b1;
      ovl = (k < ovl_n);
      if (k == restart_at) begin
        start = 1'b1; num = 16'd2; inc = 32'h4000_0000;
      end
      @(posedge clk); #1;
      vld = 1'b0; ovl = 1'b0; start = 1'b0;
      if (k < n - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    sample = 20'sd12345;
    lat = 1;
    while (!done && lat < 16) begin
      vld = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    vld = 1'b0;
    ri = iacc;
    rq = qacc;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("result_hold", iacc, ri);
  endtask

  initial begin
    longint ri, rq;
    int     lat;
    bit     seen;

    vecs[0] = '{1000,   32'h0000_0000, 16, 0, 64'sd524272000,   64'sd0};
    vecs[1] = '{-5,     32'h0000_0000, 3,  2, -64'sd491505,     64'sd0};
    vecs[2] = '{100,    32'h4000_0000, 1,  0, 64'sd3276700,     64'sd0};
    vecs[3] = '{100,    32'h4000_0000, 2,  1, 64'sd3276700,     -64'sd3276700};
    vecs[4] = '{100,    32'h4000_0000, 3,  0, 64'sd0,           -64'sd3276700};
    vecs[5] = '{-200,   32'hC000_0000, 2,  0, -64'sd6553400,    -64'sd6553400};
    vecs[6] = '{-200,   32'hC000_0000, 5,  3, -64'sd6553400,    64'sd0};
    vecs[7] = '{524287, 32'h8000_0000, 3,  0, 64'sd17179312129, 64'sd0};

    for (int k = 0; k < 16; k++) begin
      real x;
      x = 4000.0 * $cos(2.0 * 3.141592653589793 * real'(k) / 16.0);
      tone[k] = (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_i_acc", iacc, 0);
    check("rst_q_acc", qacc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run(vecs[v].smp, vecs[v].inc, vecs[v].n, vecs[v].gap, 1'b0, -1, 0, ri, rq, lat);
      check($sformatf("vec%0d_i", v), ri, vecs[v].ei);
      check($sformatf("vec%0d_q", v), rq, vecs[v].eq);
      check($sformatf("vec%0d_latency", v), lat, 3);
    end

    run(0, 32'h0, 0, 0, 1'b0, -1, 0, ri, rq, lat);
    check("n0_i", ri, 0);
    check("n0_q", rq, 0);
    check("n0_latency", lat, 2);

    run(0, 32'h1000_0000, 64, 0, 1'b1, -1, 0, ri, rq, lat);
    check_near("tone_i", ri, 64'sd4194176000, 64'sd4194176);
    check_near("tone_q", rq, 64'sd0, 64'sd4194176);
    check("tone_latency", lat, 3);

    run(3, 32'h0, 8, 0, 1'b0, 2, 3, ri, rq, lat);
    check("restart_ignored_i", ri, 64'sd786408);
    check("restart_ignored_q", rq, 0);
    check("restart_latency", lat, 3);
`ifdef SAMPLE_IQ_OVLD_CNT_EN
    check("ovld_cnt", ovld_cnt, 3);
`endif

    // Reset after 5 of 10 samples: partial sum dropped, no completion follows
    @(posedge clk); #1;
    start = 1'b1; inc = 32'h0; num = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample = 20'sd7; vld = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
    end
    rst_n = 1'b0;
    #2;
    check("midrst_i_acc", iacc, 0);
    check("midrst_q_acc", qacc, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    run(7, 32'h0, 10, 0, 1'b0, -1, 0, ri, rq, lat);
    check("after_rst_i", ri, 64'sd2293690);
    check("after_rst_q", rq, 0);
    check("after_rst_latency", lat, 3);

    run(-524288, 32'h0, 65535, 0, 1'b0, -1, 0, ri, rq, lat);
    check("negfs_i", ri, -64'sd1125848367759360);
    check("negfs_q", rq, 0);
    check("negfs_latency", lat, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_iq_accum.md
SAMPLE_IQ_ACCUM -- requirements
Module: sample_iq_accum

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 20, ADC sample width (two's complement).
REQ-002 SHALL have parameter COEF_W, default 16, signed sin/cos coefficient width (full scale +32767).
REQ-003 SHALL have parameter LUT_AW, default 8, LUT address bits (256 entries per full period).
REQ-004 SHALL have parameter PHASE_W, default 32, phase accumulator width.
REQ-005 SHALL have parameter CNT_W, default 16, sample-count width; ACC_W = SAMPLE_W+COEF_W+CNT_W (52).
REQ-006 SHALL have port i_clk input 1: clock.
REQ-007 SHALL have port i_rst_n input 1: reset, asynchronous, active-low.
REQ-008 SHALL have port i_sample input SAMPLE_W: ADC data word from the upstream ADC capture stage.
REQ-009 SHALL have port i_sample_vld input 1: one-cycle strobe, i_sample valid.
REQ-010 SHALL have port i_overload input 1: upstream overload flag, qualified by i_sample_vld.
REQ-011 SHALL have port i_start input 1: one-cycle pulse, begin a measurement.
REQ-012 SHALL have port i_phase_inc input PHASE_W: reference phase step per sample.
REQ-013 SHALL have port i_num_samples input CNT_W: samples to accumulate (N).
REQ-014 SHALL have port o_busy output 1: high from the cycle after i_start until o_done.
REQ-015 SHALL have port o_done output 1: one-cycle pulse, results valid.
REQ-016 SHALL have port o_i_acc output ACC_W: signed sum of sample*cos.
REQ-017 SHALL have port o_q_acc output ACC_W: signed sum of sample*(-sin).

Function
REQ-018 SHALL implement the states IDLE, RUN, FLUSH, DONE.
- IDLE->RUN on i_start.
- RUN->FLUSH when the Nth sample is accepted.
- FLUSH->DONE when the pipeline is empty.
- DONE->IDLE unconditionally after 1 cycle.
REQ-019 SHALL, on i_start in IDLE, latch i_phase_inc and i_num_samples, clear the phase accumulator, sample count and internal accumulators.
REQ-020 SHALL ignore i_start outside IDLE, and SHALL ignore i_sample_vld outside RUN.
REQ-021 SHALL, per accepted sample, use the phase MSBs [PHASE_W-1 -: LUT_AW] as the LUT address, then advance the phase by the latched increment with modulo-2^PHASE_W wrap.
REQ-022 SHALL use a 3-stage pipeline: registered LUT read, registered signed multiply (SAMPLE_W+COEF_W bits, full precision), sign-extended accumulate.
REQ-023 SHALL pulse o_done exactly 3 cycles after the i_sample_vld of the Nth sample; o_i_acc and o_q_acc SHALL update in the same cycle and hold until the next o_done.
REQ-024 SHALL, when N=0, pass through RUN with zero accepted samples and pulse o_done 2 cycles after i_start, with both results zero.
REQ-025 SHALL accept back-to-back i_sample_vld on consecutive cycles, with no stall and no drop.
REQ-026 SHALL not saturate the accumulators: ACC_W is sized so that any N up to 2^CNT_W-1 cannot overflow.

Reset
REQ-027 SHALL, during reset, force state IDLE, o_busy=0, o_done=0, o_i_acc=0, o_q_acc=0, all pipeline registers 0, phase 0 and count 0.
REQ-028 SHALL, when reset is asserted mid-RUN, abandon the partial sum; no o_done SHALL follow.

Configuration
REQ-029 SHALL, when SAMPLE_IQ_OVLD_CNT_EN is defined, add port o_ovld_cnt output CNT_W.
- Counts accepted samples with i_overload=1.
- Cleared on start, updated with o_done, reset 0.
REQ-030 SHALL, when SAMPLE_IQ_OVLD_CNT_EN is undefined, have no such port and ignore i_overload.

Structure
REQ-031 SHALL keep SAMPLE_W, COEF_W, LUT_AW, PHASE_W, CNT_W defaults, the derived ACC_W, and the state enum in shared package iq_pkg.
REQ-032 SHALL place the quarter-wave-symmetric sin/cos ROM in sub-module iq_sincos_lut (1-cycle registered cos and -sin outputs).

Verification
REQ-033 SHALL cover DC input: i_sample=1000, inc=0, N=16 -> o_i_acc=16*1000*32767=524272000, o_q_acc=0, o_done 3 cycles after the last vld.
REQ-034 SHALL cover on-bin tone: inc=2^28 (16 samples/period), i_sample=round(4000*cos(2*pi*k/16)), N=64 -> o_i_acc ~ 64*4000*32767/2 within 0.1%, |o_q_acc| < 0.1% of that.
REQ-035 SHALL cover N=0: i_start -> o_done 2 cycles later, both results 0; vld strobes ignored.
REQ-036 SHALL cover negative full scale: i_sample=20'h80000, inc=0, N=65535 -> o_i_acc=-524288*32767*65535 exact, no wrap.
REQ-037 SHALL cover reset mid-RUN after 5 of 10 samples -> outputs 0, no o_done; a new i_start with N=10 then yields the correct result.
REQ-038 SHALL cover i_start during RUN (ignored) together with, under SAMPLE_IQ_OVLD_CNT_EN, 3 overload samples of N=8 -> o_ovld_cnt=3.
